mux_scan_ctrl: RTL
==================

// Module: mux_scan_ctrl
// PURPOSE
//  Sequencer directly upstream/downstream of the 16:1 select mux (mux16x1 tree).
//  Drives the mux 4-bit select through channels 0..15 and waits SETTLE cycles on
//  each channel. It then samples the mux output y into a 16-bit frame. The completed
//  frame is offered downstream on a valid/ready handshake and held stable until accepted.
// PARAMETERS
//  SETTLE  1  wait cycles between a select change and its sample; legal range 0..15
// PORTS
//  clk          in   1   single clock; all state changes on rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   request one 16-channel scan; honoured only in IDLE
//  y            in   1   mux output for the channel currently on sel
//  sel          out  4   mux select (sel[0]=LSB drives s0 of the first rank)
//  busy         out  1   1 in SETTLE, SAMPLE, DONE; 0 in IDLE
//  frame        out  16  captured samples; frame[k] = y observed with sel==k
//  frame_valid  out  1   1 only in DONE; frame is stable while high
//  frame_ready  in   1   downstream accept; transfer when valid & ready at an edge
// BEHAVIOUR
//  Reset (rst=1 at an edge), from any state including mid-scan:
//   - state=IDLE, sel=0, frame=16'h0000, frame_valid=0, busy=0, wait counter=0.
//   - A partial scan is discarded.
//  States:
//   - IDLE: sel=0.
//     - start=1: if SETTLE>0, go to SETTLE with counter=SETTLE-1; else go to SAMPLE.
//     - start=0: stay in IDLE.
//   - SETTLE: counter counts down; sel holds. When counter==0, go to SAMPLE.
//   - SAMPLE: lasts one cycle; frame[sel] <= y.
//     - sel==15: go to DONE; sel holds at 15.
//     - otherwise: sel <= sel+1, then go to SETTLE (counter=SETTLE-1) or, if SETTLE==0,
//       stay in SAMPLE.
//   - DONE: frame_valid=1. frame_ready=1 at an edge -> IDLE, sel<=0, frame_valid<=0.
//  frame bits are written only in SAMPLE. They are never cleared except by reset;
//   each scan overwrites all 16 bits.
//  Latency: start accepted at edge E0 -> frame_valid high after edge E0+16*(SETTLE+1).
//   - Each channel occupies exactly SETTLE+1 cycles.
//  start is ignored outside IDLE. In particular, start in DONE does not re-arm.
//  start and frame_ready high in the same DONE cycle: the handshake completes and the
//   block returns to IDLE. start must be re-presented there to begin a new scan.
//  frame_ready is ignored when frame_valid=0.
//  sel wraps never: the max is 15, and return to 0 happens only via DONE->IDLE or reset.
//  Outputs are registered, or decoded from the state register only; no comb path from
//   y/start/frame_ready to any output.
// TESTING
//  1. SETTLE=1, y driven as bit sel of 16'hA5C3, start pulse at E0 -> frame_valid at
//     E0+32, frame==16'hA5C3, sel==15.
//  2. SETTLE=0, y = parity of sel -> frame==16'h6996 at E0+16; sel steps every cycle.
//  3. Backpressure: hold frame_ready=0 for 10 cycles in DONE -> frame_valid,frame stable;
//     start pulses ignored. Then ready=1 -> IDLE next cycle, sel=0, busy=0.
//  4. rst=1 while sel==7 mid-scan -> next edge: IDLE, sel=0, frame=0, valid=0.
//     A new start then gives a full correct frame.
//  5. start held high continuously, ready tied 1 -> back-to-back scans. Each scan
//     restarts one cycle after DONE, giving a period of 16*(SETTLE+1)+2 cycles.
//  6. SETTLE=3, y changes while in SETTLE -> only the value present in the SAMPLE cycle
//     is captured.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
//
// Scan sequencer for a 16:1 select mux. On a start request in IDLE it steps
// the mux select through channels 0..15. Each channel is given SETTLE wait
// cycles for the mux path to settle, followed by one SAMPLE cycle in which
// the mux output y is stored into frame[sel]. The completed 16-bit frame is
// offered downstream with a valid/ready handshake and held until accepted.
//
// Parameters
//   SETTLE       wait cycles between a select change and its sample (0..15)
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous, active-high reset
//   start        in   1   request one 16-channel scan (only seen in IDLE)
//   y            in   1   mux output for the channel currently on sel
//   sel          out  4   mux select, registered
//   busy         out  1   high whenever a scan or handshake is in progress
//   frame        out  16  captured samples, frame[k] = y seen with sel==k
//   frame_valid  out  1   high while a finished frame awaits acceptance
//   frame_ready  in   1   downstream accept, transfer on valid & ready
//
// Every output comes straight from a flop, so there is no combinational
// path from y, start or frame_ready to any output.
// -----------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        y,
    output logic [3:0]  sel,
    output logic        busy,
    output logic [15:0] frame,
    output logic        frame_valid,
    input  logic        frame_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With SETTLE==0 the SETTLE state is never entered; a channel is then a
    // single SAMPLE cycle and the block stays in SAMPLE while sel advances.
    localparam logic       HAS_SETTLE = (SETTLE > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] RELOAD     = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [3:0] LAST_CH    = 4'd15;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [3:0]  sel_r;
    logic [3:0]  sel_s;
    logic [15:0] frame_r;
    logic [15:0] frame_s;
    logic        busy_r;
    logic        busy_s;
    logic        valid_r;
    logic        valid_s;

    // Next-state, counter, select and frame update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        sel_s   = sel_r;
        frame_s = frame_r;

        case (state_r)
            ST_IDLE: begin
                sel_s = 4'd0;
                if (start) begin
                    if (HAS_SETTLE) begin
                        state_s = ST_SETTLE;
                        cnt_s   = RELOAD;
                    end else begin
                        state_s = ST_SAMPLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                // Counter was loaded with SETTLE-1, so this state lasts
                // exactly SETTLE cycles before the sample cycle.
                if (cnt_r == 4'd0) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end

            ST_SAMPLE: begin
                frame_s[sel_r] = y;
                if (sel_r == LAST_CH) begin
                    // sel stays at 15; it only returns to 0 via DONE->IDLE.
                    state_s = ST_DONE;
                end else begin
                    sel_s = sel_r + 4'd1;
                    if (HAS_SETTLE) begin
                        state_s = ST_SETTLE;
                        cnt_s   = RELOAD;
                    end else begin
                        state_s = ST_SAMPLE;
                    end
                end
            end

            ST_DONE: begin
                // start is deliberately not looked at here: a new scan needs
                // start to be presented again once back in IDLE.
                if (frame_ready) begin
                    state_s = ST_IDLE;
                    sel_s   = 4'd0;
                end else begin
                    state_s = ST_DONE;
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                sel_s   = 4'd0;
            end
        endcase
    end

    // Status outputs are computed from the next state so they can be
    // registered and still line up with the state register.
    always_comb begin
        busy_s  = 1'b0;
        valid_s = 1'b0;
        if (state_s == ST_IDLE) begin
            busy_s = 1'b0;
        end else begin
            busy_s = 1'b1;
        end
        if (state_s == ST_DONE) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    // State, counter, select, frame and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            sel_r   <= 4'd0;
            frame_r <= 16'h0000;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            sel_r   <= sel_s;
            frame_r <= frame_s;
            busy_r  <= busy_s;
            valid_r <= valid_s;
        end
    end

    assign sel         = sel_r;
    assign frame       = frame_r;
    assign busy        = busy_r;
    assign frame_valid = valid_r;

endmodule
